// File: rtl/dsi_pkt_builder.sv
// dsi_pkt_builder: assembles DSI short/long packets from a command descriptor
// and an optional payload byte stream. It generates the header ECC and drives
// an external CRC-16 engine. The CRC engine's result is appended as the
// long-packet footer.
module dsi_pkt_builder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_long,
  input  logic [1:0]  cmd_vc,
  input  logic [5:0]  cmd_dt,
  input  logic [15:0] cmd_wc,
  input  logic        pl_valid,
  output logic        pl_ready,
  input  logic [7:0]  pl_data,
  output logic        crc_clr,
  output logic        crc_en,
  output logic [7:0]  crc_byte,
  input  logic [15:0] crc_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC_LO  = 3'd3,
    ST_CRC_HI  = 3'd4
  } state_t;

  state_t      state_r;
  logic [7:0]  di_r;       // {vc, dt}
  logic [15:0] wc_r;       // word count or {data1, data0}
  logic        long_r;
  logic [15:0] cnt_r;      // payload bytes already transferred
  logic [1:0]  hdr_idx_r;  // header byte being presented
  logic        live_r;     // low during reset and for the first cycle after it
  logic [7:0]  ecc_s;
  logic        pl_xfer_s;

  // MIPI DSI 6-bit Hamming parity over the 24-bit packet header.
  function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

  assign ecc_s     = {2'b00, hdr_ecc({wc_r, di_r})};
  assign pl_xfer_s = pl_valid & tx_ready;

  // Output decode from the registered state; the payload phase is a direct pass-through.
  always_comb begin
    cmd_ready = 1'b0;
    pl_ready  = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_byte  = 8'h00;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = live_r;
        crc_clr   = cmd_valid & live_r;
      end
      ST_HDR: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_sop   = (hdr_idx_r == 2'd0);
        tx_eop   = (hdr_idx_r == 2'd3) & ~long_r;
        case (hdr_idx_r)
          2'd0:    tx_data = di_r;
          2'd1:    tx_data = wc_r[7:0];
          2'd2:    tx_data = wc_r[15:8];
          2'd3:    tx_data = ecc_s;
          default: tx_data = 8'h00;
        endcase
      end
      ST_PAYLOAD: begin
        busy     = 1'b1;
        tx_valid = pl_valid;
        tx_data  = pl_data;
        pl_ready = tx_ready;
        crc_en   = pl_xfer_s;
        crc_byte = pl_xfer_s ? pl_data : 8'h00;
      end
      ST_CRC_LO: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = crc_data[7:0];
      end
      ST_CRC_HI: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = crc_data[15:8];
        tx_eop   = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Packet sequencer: latches the descriptor and advances on each byte transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      di_r      <= 8'h00;
      wc_r      <= 16'h0000;
      long_r    <= 1'b0;
      cnt_r     <= 16'h0000;
      hdr_idx_r <= 2'd0;
      live_r    <= 1'b0;
    end else begin
      live_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && live_r) begin
            di_r      <= {cmd_vc, cmd_dt};
            wc_r      <= cmd_wc;
            long_r    <= cmd_long;
            cnt_r     <= 16'h0000;
            hdr_idx_r <= 2'd0;
            state_r   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (tx_ready) begin
            if (hdr_idx_r == 2'd3) begin
              if (!long_r) begin
                state_r <= ST_IDLE;
              end else if (wc_r == 16'h0000) begin
                state_r <= ST_CRC_LO;
              end else begin
                state_r <= ST_PAYLOAD;
              end
            end else begin
              hdr_idx_r <= hdr_idx_r + 2'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (pl_xfer_s) begin
            cnt_r <= cnt_r + 16'd1;
            // Compare against wc-1 so that wc=0xFFFF ends without the counter wrapping.
            if (cnt_r == (wc_r - 16'd1)) begin
              state_r <= ST_CRC_LO;
            end
          end
        end
        ST_CRC_LO: begin
          if (tx_ready) begin
            state_r <= ST_CRC_HI;
          end
        end
        ST_CRC_HI: begin
          if (tx_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_pkt_builder.sv
// tb_dsi_pkt_builder: directed and randomized packets checked against a
// byte-level packet model. The bench also provides a CRC-16 engine.
module tb_dsi_pkt_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_long = 1'b0;
  logic [1:0]  cmd_vc = 2'd0;
  logic [5:0]  cmd_dt = 6'd0;
  logic [15:0] cmd_wc = 16'd0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [7:0]  pl_data = 8'd0;
  logic        crc_clr;
  logic        crc_en;
  logic [7:0]  crc_byte;
  logic [15:0] crc_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic        busy;

  always #5 clk = ~clk;

  dsi_pkt_builder dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_long(cmd_long),
    .cmd_vc(cmd_vc), .cmd_dt(cmd_dt), .cmd_wc(cmd_wc),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .crc_clr(crc_clr), .crc_en(crc_en), .crc_byte(crc_byte), .crc_data(crc_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .busy(busy)
  );

  // Reflected CRC-16 (x^16+x^12+x^5+1), bytes fed LSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Stand-in for the external CRC engine: registered result, clear/update strobes.
  logic [15:0] eng_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      eng_r <= 16'hFFFF;
    else if (crc_clr) eng_r <= 16'hFFFF;
    else if (crc_en)  eng_r <= crc_step(eng_r, crc_byte);
  end
  assign crc_data = eng_r;

  // Header ECC from per-parity-bit coverage masks.
  function automatic logic [7:0] ecc_ref(input logic [23:0] d);
    logic [23:0] m [0:5];
    logic [7:0]  r;
    m[0] = 24'hF12CB7; m[1] = 24'hF2555B; m[2] = 24'h749A6D;
    m[3] = 24'hB8E38E; m[4] = 24'hDF03F0; m[5] = 24'hEFFC00;
    r = 8'h00;
    for (int i = 0; i < 6; i++) r[i] = ^(d & m[i]);
    return r;
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] pl_q[$];
  logic [7:0] got_q[$];
  logic [1:0] flg_q[$];
  logic [7:0] ref_q[$];
  int cyc = 0;
  int a_cyc, first_cyc, eop_cyc, acc2_cyc, pidx, n_clr, n_en, n_plr, n_bad_cb;
  bit done;
  logic [1:0]  nx_vc;
  logic [5:0]  nx_dt;
  logic [15:0] nx_wc;

  // Drives one packet cycle by cycle; inputs change 1 time unit after posedge, outputs sampled on negedge.
  task automatic run_pkt(input bit lng, input logic [1:0] vc, input logic [5:0] dt,
                         input logic [15:0] wc, input bit thr, input int abort_at,
                         input bit hold, input bit pre_acc);
    bit acc;
    acc = pre_acc;
    got_q.delete(); flg_q.delete();
    n_clr = 0; n_en = 0; n_plr = 0; n_bad_cb = 0; pidx = 0;
    a_cyc = -1; first_cyc = -1; eop_cyc = -1; acc2_cyc = -1; done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(posedge clk); #1;
      if (abort_at >= 0 && pidx == abort_at) return;
      cmd_valid = !acc || hold;
      if (acc && hold) begin
        cmd_long = 1'b0; cmd_vc = nx_vc; cmd_dt = nx_dt; cmd_wc = nx_wc;
      end else begin
        cmd_long = lng; cmd_vc = vc; cmd_dt = dt; cmd_wc = wc;
      end
      tx_ready = thr ? ($urandom_range(0, 2) != 0) : 1'b1;
      pl_valid = thr ? ($urandom_range(0, 1) == 1) : 1'b1;
      pl_data  = (pidx < pl_q.size()) ? pl_q[pidx] : 8'hEE;
      @(negedge clk);
      cyc++;
      if (crc_clr) n_clr++;
      if (crc_en) n_en++;
      else if (crc_byte !== 8'h00) n_bad_cb++;
      if (pl_ready) n_plr++;
      if (pl_valid && pl_ready) pidx++;
      if (tx_valid && tx_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        got_q.push_back(tx_data);
        flg_q.push_back({tx_sop, tx_eop});
        if (tx_eop) begin
          eop_cyc = cyc;
          if (!hold) done = 1;
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (!acc) begin
          acc = 1; a_cyc = cyc;
        end else begin
          acc2_cyc = cyc; done = 1;
        end
      end
    end
    chk("timeout", 32'(done), 32'd1);
  endtask

  // Builds the expected byte stream from the packet rules and compares it with what was captured.
  task automatic check_pkt(input string tag, input bit lng, input logic [1:0] vc,
                           input logic [5:0] dt, input logic [15:0] wc, input int exp_clr);
    logic [7:0]  ex[$];
    logic [15:0] c;
    int n;
    ex.push_back({vc, dt});
    ex.push_back(wc[7:0]);
    ex.push_back(wc[15:8]);
    ex.push_back(ecc_ref({wc, vc, dt}));
    if (lng) begin
      c = 16'hFFFF;
      for (int i = 0; i < int'(wc); i++) begin
        ex.push_back(pl_q[i]);
        c = crc_step(c, pl_q[i]);
      end
      ex.push_back(c[7:0]);
      ex.push_back(c[15:8]);
    end
    chk({tag, ".len"}, 32'(got_q.size()), 32'(ex.size()));
    n = (got_q.size() < ex.size()) ? got_q.size() : ex.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.byte%0d", tag, i), 32'(got_q[i]), 32'(ex[i]));
      chk($sformatf("%s.flags%0d", tag, i), 32'(flg_q[i]),
          32'({i == 0, i == ex.size() - 1}));
    end
    chk({tag, ".crc_en"}, 32'(n_en), lng ? 32'(wc) : 32'd0);
    chk({tag, ".crc_clr"}, 32'(n_clr), 32'(exp_clr));
    chk({tag, ".crc_byte_idle"}, 32'(n_bad_cb), 32'd0);
    chk({tag, ".pl_taken"}, 32'(pidx), lng ? 32'(wc) : 32'd0);
    if (!lng) chk({tag, ".pl_ready"}, 32'(n_plr), 32'd0);
  endtask

  initial begin
    logic [15:0] wc;
    logic        lng;
    logic [1:0]  vc;
    logic [5:0]  dt;

    // Reset state.
    #1;
    chk("rst.outs", 32'({cmd_ready, pl_ready, tx_valid, tx_sop, tx_eop, crc_en, crc_clr, busy}), 32'd0);
    chk("rst.data", 32'({tx_data, crc_byte}), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("post_rst.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst.busy", 32'({busy, tx_valid}), 32'd0);

    // Short packet: DCS write with one parameter.
    pl_q.delete();
    run_pkt(1'b0, 2'd0, 6'h15, 16'h00B0, 1'b0, -1, 1'b0, 1'b0);
    check_pkt("short", 1'b0, 2'd0, 6'h15, 16'h00B0, 1);
    chk("short.di_latency", 32'(first_cyc - a_cyc), 32'd1);
    chk("short.eop_latency", 32'(eop_cyc - a_cyc), 32'd4);

    // Long packet, three payload bytes.
    pl_q = '{8'hB0, 8'h01, 8'h02};
    run_pkt(1'b1, 2'd0, 6'h39, 16'd3, 1'b0, -1, 1'b0, 1'b0);
    check_pkt("long3", 1'b1, 2'd0, 6'h39, 16'd3, 1);
    if (got_q.size() > 3) chk("long3.ecc_const", 32'(got_q[3]), 32'h09);
    chk("long3.cycles", 32'(eop_cyc - a_cyc), 32'd9);

    // Long packet with empty payload: footer is the seed.
    pl_q.delete();
    run_pkt(1'b1, 2'd0, 6'h39, 16'd0, 1'b0, -1, 1'b0, 1'b0);
    check_pkt("long0", 1'b1, 2'd0, 6'h39, 16'd0, 1);
    if (got_q.size() == 6) chk("long0.footer", 32'({got_q[4], got_q[5]}), 32'hFFFF);
    chk("long0.cycles", 32'(eop_cyc - a_cyc), 32'd6);

    // wc=16 unthrottled, then the same packet throttled on both sides.
    pl_q.delete();
    for (int i = 0; i < 16; i++) pl_q.push_back(8'($urandom));
    run_pkt(1'b1, 2'd1, 6'h29, 16'd16, 1'b0, -1, 1'b0, 1'b0);
    check_pkt("w16", 1'b1, 2'd1, 6'h29, 16'd16, 1);
    chk("w16.cycles", 32'(eop_cyc - a_cyc), 32'd22);
    ref_q = got_q;
    run_pkt(1'b1, 2'd1, 6'h29, 16'd16, 1'b1, -1, 1'b0, 1'b0);
    check_pkt("w16thr", 1'b1, 2'd1, 6'h29, 16'd16, 1);
    chk("w16thr.len_vs_unthr", 32'(got_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
      chk($sformatf("w16thr.same%0d", i), 32'(got_q[i]), 32'(ref_q[i]));

    // Randomized packets with throttling.
    for (int p = 0; p < 6; p++) begin
      lng = 1'($urandom);
      vc  = 2'($urandom);
      dt  = 6'($urandom);
      wc  = lng ? 16'($urandom_range(1, 12)) : 16'($urandom);
      pl_q.delete();
      for (int i = 0; i < 12; i++) pl_q.push_back(8'($urandom));
      run_pkt(lng, vc, dt, wc, 1'b1, -1, 1'b0, 1'b0);
      check_pkt($sformatf("rnd%0d", p), lng, vc, dt, wc, 1);
    end

    // Reset while payload byte 5 of a wc=10 packet is presented.
    pl_q.delete();
    for (int i = 0; i < 10; i++) pl_q.push_back(8'($urandom));
    run_pkt(1'b1, 2'd2, 6'h39, 16'd10, 1'b0, 5, 1'b0, 1'b0);
    chk("abort.in_payload", 32'({busy, pl_ready, crc_en}), 32'h7);
    chk("abort.no_eop", 32'(eop_cyc), 32'hFFFFFFFF);
    rst_n = 1'b0;
    #1;
    chk("abort.rst_outs", 32'({cmd_ready, pl_ready, tx_valid, tx_sop, tx_eop, crc_en, crc_clr, busy}), 32'd0);
    chk("abort.rst_data", 32'({tx_data, crc_byte}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pl_valid = 1'b0;
    pl_q.delete();
    run_pkt(1'b0, 2'd3, 6'h05, 16'h0028, 1'b0, -1, 1'b0, 1'b0);
    check_pkt("after_abort", 1'b0, 2'd3, 6'h05, 16'h0028, 1);

    // cmd_valid held high across two short descriptors.
    nx_vc = 2'd0; nx_dt = 6'h15; nx_wc = 16'h2936;
    run_pkt(1'b0, 2'd0, 6'h05, 16'h0011, 1'b0, -1, 1'b1, 1'b0);
    check_pkt("b2b_first", 1'b0, 2'd0, 6'h05, 16'h0011, 2);
    if (got_q.size() > 3) chk("b2b_first.ecc_const", 32'(got_q[3]), 32'h36);
    chk("b2b.second_accept", 32'(acc2_cyc), 32'(eop_cyc + 1));
    run_pkt(1'b0, 2'd0, 6'h15, 16'h2936, 1'b0, -1, 1'b0, 1'b1);
    check_pkt("b2b_second", 1'b0, 2'd0, 6'h15, 16'h2936, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsi_pkt_builder.md
# dsi_pkt_builder

Packet assembler for the DSI LCM-init command path: accepts one command descriptor plus an optional payload byte stream and emits a serialized DSI packet byte stream toward the lane distributor. For long packets it drives the external CRC-16 engine byte-by-byte (G(x)=x^16+x^12+x^5+1, seed 0xFFFF) and appends that engine's result as the packet footer. Short packets are passed through with header ECC only.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  descriptor accepted when cmd_valid & cmd_ready
- cmd_long  in  1  1 = long packet (header+payload+CRC), 0 = short packet (header only)
- cmd_vc  in  2  virtual channel
- cmd_dt  in  6  data type
- cmd_wc  in  16  long: word count (payload bytes); short: {data1, data0}
- pl_valid  in  1  payload byte valid
- pl_ready  out  1  payload byte accepted when pl_valid & pl_ready
- pl_data  in  8  payload byte
- crc_clr  out  1  one-cycle clear pulse to CRC engine
- crc_en  out  1  CRC engine update strobe
- crc_byte  out  8  byte presented to CRC engine
- crc_data  in  16  registered CRC engine result
- tx_valid  out  1  output byte valid
- tx_ready  in  1  downstream accepts byte when tx_valid & tx_ready
- tx_data  out  8  output byte
- tx_sop  out  1  marks first byte (DI) of a packet
- tx_eop  out  1  marks last byte of a packet
- busy  out  1  high from descriptor accept until last byte transferred

## Operation
- States: IDLE, HDR, PAYLOAD, CRC_LO, CRC_HI.
- IDLE: cmd_ready=1. On cmd_valid: latch vc/dt/wc/long, pulse crc_clr for that cycle, clear byte counter, go HDR.
- HDR: emits 4 bytes in order DI={vc,dt}, wc[7:0], wc[15:8], ECC. ECC = {2'b00, P5..P0}, MIPI DSI 6-bit Hamming parity over 24-bit header D[23:0]={wc_h,wc_l,DI}; computed combinationally from latched fields.
- After ECC byte transfer: short -> IDLE; long with wc=0 -> CRC_LO; long with wc>0 -> PAYLOAD.
- PAYLOAD: pass-through. tx_valid=pl_valid, tx_data=pl_data, pl_ready=tx_ready. On each transfer: crc_en=1, crc_byte=pl_data, counter++. On transfer of byte wc-1 -> CRC_LO. pl_ready=0 in all other states; excess payload bytes stall upstream.
- CRC_LO: emits crc_data[7:0]; CRC_HI: emits crc_data[15:8] with tx_eop; then IDLE.
- tx_sop=1 only on DI byte; tx_eop=1 on ECC byte (short) or CRC_HI byte (long).
- crc_en is never asserted outside PAYLOAD transfers; crc_byte=0 when crc_en=0.
- Counter 16-bit; wc=0xFFFF supported with no wrap before termination.

## Timing
- Reset (async): state IDLE; cmd_ready=0 while rst_n low, then 1; pl_ready, tx_valid, tx_sop, tx_eop, crc_en, crc_clr, busy = 0; tx_data, crc_byte = 0; latched fields cleared.
- Accept in cycle N -> DI byte valid in N+1 (tx_valid held until tx_ready). No back-to-back: next descriptor accepted no earlier than the cycle after the final byte transfer.
- Output byte held stable while tx_valid & !tx_ready (AXIS-style rules; valid never drops without transfer, except PAYLOAD where it tracks pl_valid).
- CRC engine updates on clock after crc_en; last payload byte in cycle M -> crc_data final in M+1 = first CRC_LO cycle. No wait state needed.
- Throughput: one byte per cycle with tx_ready held high; long packet of wc bytes = wc+6 cycles after accept.
- Reset mid-packet: immediate return to IDLE; partial packet abandoned with no eop; next packet starts with crc_clr.

## Test plan
- Short packet vc=0, dt=0x15, wc=0x00B0 (DCS write 1 param, 0xB0 cmd) -> bytes 0x15,0xB0,0x00,ECC per parity model, sop on first, eop on fourth, pl_ready never high.
- Long packet vc=0, dt=0x39, wc=3, payload 0xB0,0x01,0x02 -> header 0x39,0x03,0x00,0x09, payload, then CRC lo/hi equal to bench CRC model after three crc_en pulses; crc_clr pulsed once at accept.
- Long packet wc=0 -> 0x39,0x00,0x00,ECC,0xFF,0xFF; crc_en never asserted.
- Random tx_ready and pl_valid throttling on wc=16 packet -> byte stream identical to unthrottled run; no duplicated/dropped bytes; crc_en count = 16.
- rst_n asserted during PAYLOAD byte 5 of wc=10 -> all outputs at reset values same cycle; following short packet emitted correctly with sop.
- cmd_valid held high across two descriptors -> second accepted only in cycle after first packet's eop transfer.
